// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Two-requester round-robin arbiter in front of the single data port of the
// on-chip byte-lane RAM. Requester 0 is the CPU dBus, requester 1 a secondary
// master (DMA / loader). Only RAM-bound commands arrive here; peripheral decode
// happens upstream.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   rN_cmd_valid/ready      command handshake (ready = granted this cycle)
//   rN_cmd_wr               1 = write, 0 = read
//   rN_cmd_addr             byte address
//   rN_cmd_wdata            lane-aligned write data
//   rN_cmd_size             0 = byte, 1 = half, 2/3 = word
//   rN_rsp_valid/error      one-cycle read response, error = out of range
//   rN_rsp_rdata            read data, holds last value between responses
//   mem_en/addr/be/wdata    RAM command (word index, per-lane write enables)
//   mem_rdata               RAM read data, valid the cycle after mem_en
// -----------------------------------------------------------------------------
module dmem_arbiter #(
   parameter int ADDR_BITS = 12,
   parameter int RST_GRANT = 0
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 r0_cmd_valid,
   output logic                 r0_cmd_ready,
   input  logic                 r0_cmd_wr,
   input  logic [31:0]          r0_cmd_addr,
   input  logic [31:0]          r0_cmd_wdata,
   input  logic [1:0]           r0_cmd_size,
   output logic                 r0_rsp_valid,
   output logic                 r0_rsp_error,
   output logic [31:0]          r0_rsp_rdata,
   input  logic                 r1_cmd_valid,
   output logic                 r1_cmd_ready,
   input  logic                 r1_cmd_wr,
   input  logic [31:0]          r1_cmd_addr,
   input  logic [31:0]          r1_cmd_wdata,
   input  logic [1:0]           r1_cmd_size,
   output logic                 r1_rsp_valid,
   output logic                 r1_rsp_error,
   output logic [31:0]          r1_rsp_rdata,
   output logic                 mem_en,
   output logic [ADDR_BITS-3:0] mem_addr,
   output logic [3:0]           mem_be,
   output logic [31:0]          mem_wdata,
   input  logic [31:0]          mem_rdata
);

   // Priority pointer value after reset: 1 means requester 1 wins a tie.
   localparam logic RST_PRIO = (RST_GRANT != 0) ? 1'b1 : 1'b0;

   // Byte enables from access size and the low address bits.
   function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] a);
      logic [3:0] be;
      case (size)
         2'd0:    be = 4'b0001 << a;
         2'd1:    be = a[1] ? 4'b1100 : 4'b0011;   // addr[0] ignored
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   logic        prio_r;        // 1: requester 1 wins a tie
   logic        pend_valid_r;  // a read was granted last cycle
   logic        pend_owner_r;  // requester that issued it
   logic        pend_err_r;    // it was out of range
   logic [31:0] r0_hold_r;
   logic [31:0] r1_hold_r;

   logic        gnt0_s;
   logic        gnt1_s;
   logic        any_gnt_s;
   logic        sel_wr_s;
   logic [31:0] sel_addr_s;
   logic [31:0] sel_wdata_s;
   logic [1:0]  sel_size_s;
   logic        oor_s;
   logic [31:0] rsp_data_s;

   // Grant decision; no grants are issued while reset is asserted.
   always_comb begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
      if (reset_n) begin
         if (r0_cmd_valid && r1_cmd_valid) begin
            gnt0_s = ~prio_r;
            gnt1_s = prio_r;
         end else begin
            gnt0_s = r0_cmd_valid;
            gnt1_s = r1_cmd_valid;
         end
      end else begin
         gnt0_s = 1'b0;
         gnt1_s = 1'b0;
      end
   end

   // Select the granted requester's command (requester 0 when idle).
   always_comb begin
      sel_wr_s    = r0_cmd_wr;
      sel_addr_s  = r0_cmd_addr;
      sel_wdata_s = r0_cmd_wdata;
      sel_size_s  = r0_cmd_size;
      if (gnt1_s) begin
         sel_wr_s    = r1_cmd_wr;
         sel_addr_s  = r1_cmd_addr;
         sel_wdata_s = r1_cmd_wdata;
         sel_size_s  = r1_cmd_size;
      end else begin
         sel_wr_s    = r0_cmd_wr;
         sel_addr_s  = r0_cmd_addr;
         sel_wdata_s = r0_cmd_wdata;
         sel_size_s  = r0_cmd_size;
      end
   end

   assign any_gnt_s    = gnt0_s | gnt1_s;
   assign oor_s        = |sel_addr_s[31:ADDR_BITS];
   assign r0_cmd_ready = gnt0_s;
   assign r1_cmd_ready = gnt1_s;

   // Memory command; out-of-range accesses still strobe mem_en (harmless
   // read) but never write.
   always_comb begin
      mem_en    = any_gnt_s;
      mem_addr  = sel_addr_s[ADDR_BITS-1:2];
      mem_wdata = sel_wdata_s;
      if (any_gnt_s && sel_wr_s && !oor_s) begin
         mem_be = lane_be(sel_size_s, sel_addr_s[1:0]);
      end else begin
         mem_be = 4'b0000;
      end
   end

   // Round-robin pointer: the ungranted requester gets priority next time.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prio_r <= RST_PRIO;
      end else if (any_gnt_s) begin
         prio_r <= gnt0_s;
      end else begin
         prio_r <= prio_r;
      end
   end

   // Pending read response; cleared by reset so an in-flight read is dropped.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend_valid_r <= 1'b0;
         pend_owner_r <= 1'b0;
         pend_err_r   <= 1'b0;
      end else begin
         pend_valid_r <= any_gnt_s & ~sel_wr_s;
         pend_owner_r <= gnt1_s;
         pend_err_r   <= oor_s;
      end
   end

   assign rsp_data_s = pend_err_r ? 32'h0000_0000 : mem_rdata;

   // Per-requester copy of the last delivered read data.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r0_hold_r <= 32'h0000_0000;
         r1_hold_r <= 32'h0000_0000;
      end else begin
         if (pend_valid_r && !pend_owner_r) begin
            r0_hold_r <= rsp_data_s;
         end else begin
            r0_hold_r <= r0_hold_r;
         end
         if (pend_valid_r && pend_owner_r) begin
            r1_hold_r <= rsp_data_s;
         end else begin
            r1_hold_r <= r1_hold_r;
         end
      end
   end

   // Response routing: RAM data flows straight through in the response cycle.
   assign r0_rsp_valid = pend_valid_r & ~pend_owner_r;
   assign r1_rsp_valid = pend_valid_r &  pend_owner_r;
   assign r0_rsp_error = r0_rsp_valid & pend_err_r;
   assign r1_rsp_error = r1_rsp_valid & pend_err_r;
   assign r0_rsp_rdata = r0_rsp_valid ? rsp_data_s : r0_hold_r;
   assign r1_rsp_rdata = r1_rsp_valid ? rsp_data_s : r1_hold_r;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester round-robin arbiter sharing the single data port of the on-chip byte-lane program/data RAM.
- Requester 0 is the CPU dBus; requester 1 is a secondary master such as a DMA or loader.
- Generates byte enables from size and address, and range-checks addresses.
- Routes the fixed 1-cycle read response back to the requester that issued the command.
- Peripheral decode (address bit 31) stays outside this block; only RAM-bound commands arrive here.

Parameters:
- ADDR_BITS, 12, byte-address width of the RAM (4096 bytes); word index is ADDR_BITS-2 bits.
- RST_GRANT, 0, requester that holds round-robin priority after reset (0 or 1).

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- r0_cmd_valid  in  1  requester 0 command valid
- r0_cmd_ready  out  1  requester 0 command accepted this cycle
- r0_cmd_wr  in  1  1=write, 0=read
- r0_cmd_addr  in  32  byte address
- r0_cmd_wdata  in  32  write data, lane-aligned
- r0_cmd_size  in  2  0=byte, 1=half, 2/3=word
- r0_rsp_valid  out  1  read response valid
- r0_rsp_error  out  1  read response error
- r0_rsp_rdata  out  32  read data
- r1_*  —  same nine signals as r0_*, for requester 1
- mem_en  out  1  RAM access this cycle
- mem_addr  out  ADDR_BITS-2  RAM word index
- mem_be  out  4  per-lane write enables, 0 for reads
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM read data, valid the cycle after mem_en

Interface: one clock; reset is asynchronous and active-low. Ports are clk and reset_n.

Behaviour:
- Reset (reset_n low, async): all rsp_valid/rsp_error = 0; rsp_rdata = 0; priority pointer = RST_GRANT; pending-response register cleared.
- Reset deassertion mid-transaction: any in-flight read response is dropped, with no rsp_valid afterwards.
- Grant is combinational, at most one per cycle; rN_cmd_ready = grant to N.
  - Only one valid: that requester is granted.
  - Both valid: the requester named by the priority pointer is granted.
  - Pointer update on each grant: pointer <= the other requester, i.e. the ungranted one has priority next time.
  - Pointer is unchanged on idle cycles.
- No wait states. A granted command is accepted in the same cycle; valid may drop afterwards. A requester must hold its command stable while valid && !ready.
- Range check: addr[31:ADDR_BITS] != 0 means out of range.
  - Out-of-range write: silently discarded, mem_be = 0.
  - Out-of-range read: response with error.
- Byte enables, with a = addr[1:0]:
  - size 0: 4'b0001 << a.
  - size 1: 4'b0011 << a[1]*2, half-aligned; addr[0] is ignored.
  - size 2/3: 4'b1111.
- Memory side on the grant cycle:
  - mem_en = 1, including out-of-range accesses (harmless read).
  - mem_addr = addr[ADDR_BITS-1:2]; mem_wdata = cmd_wdata.
  - mem_be = (wr && in-range) ? byte enables : 0.
- Read response, cycle N+1 after a read is granted in cycle N:
  - The granted requester sees rsp_valid = 1 for exactly one cycle.
  - rsp_rdata = mem_rdata, or 0 if errored.
  - rsp_error = registered out-of-range flag.
  - The other requester's rsp_valid stays 0.
- Writes produce no response.
- Back-to-back reads, including alternating owners, sustain one per cycle.
- rsp_rdata holds its last value when rsp_valid = 0.

Test Plan:
- Reset: reset_n low with both cmd_valid=1 -> all rsp_valid=0, mem_be=0; first grant after release goes to RST_GRANT=0.
- Contention: both valid reads every cycle for 6 cycles -> grants 0,1,0,1,0,1; rsp_valid alternates r0/r1 one cycle later with the matching mem_rdata.
- Byte write: r1 wr, addr 0x0000_0006, size 0, wdata 0x00AB0000 -> mem_addr=1, mem_be=4'b0100, r1_cmd_ready=1, no rsp.
- Half write at addr 0x00C, size 1 -> mem_be=4'b0011; then a read at addr 0x00C (size 2) -> rsp_valid after 1 cycle with mem_rdata, rsp_error=0.
- Out of range: r0 read at 0x0000_1000 -> r0_rsp_valid=1, r0_rsp_error=1, rdata 0; r0 write at 0x0000_2000 -> mem_be=0.
- Mid-flight reset: r0 read granted, reset_n pulsed low in the response cycle -> r0_rsp_valid=0 and stays 0 until a new read.
